// File: rtl/softmax_argmax_pkg.sv
// Shared definitions for the classification-head argmax reducer.
// State encoding and default score width are common with the softmax PE.
package softmax_argmax_pkg;

    localparam int DEF_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/argmax_cmp.sv
// Signed compare-and-select: keeps the current winner unless the new score is strictly greater.
// Latency: combinational, 0 cycles.
// Backpressure: none, pure function of its inputs.
module argmax_cmp
    import softmax_argmax_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int IDX_WIDTH  = 4
)(
    input  logic [DATA_WIDTH-1:0] cur_max,
    input  logic [IDX_WIDTH-1:0]  cur_idx,
    input  logic [DATA_WIDTH-1:0] new_dat,
    input  logic [IDX_WIDTH-1:0]  new_idx,
    output logic                  take_new,
    output logic [DATA_WIDTH-1:0] sel_max,
    output logic [IDX_WIDTH-1:0]  sel_idx
);

    // Strict compare so that on a tie the earlier (current) index survives.
    assign take_new = $signed(new_dat) > $signed(cur_max);
    assign sel_max  = take_new ? new_dat : cur_max;
    assign sel_idx  = take_new ? new_idx : cur_idx;

endmodule

// File: rtl/softmax_argmax.sv
// Streams NUM_CLASS signed scores per frame and reports the max score and its index.
// Latency: result valid the cycle after the final beat is accepted.
// Backpressure: in_ready drops while a result is held; result held until out_ready.
module softmax_argmax
    import softmax_argmax_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_CLASS  = 10,
    parameter int IDX_WIDTH  = 4
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [IDX_WIDTH-1:0]  out_idx,
    output logic [DATA_WIDTH-1:0] out_max
);

    localparam logic [IDX_WIDTH:0] CNT_ONE  = (IDX_WIDTH+1)'(1);
    localparam logic [IDX_WIDTH:0] LAST_CNT = (IDX_WIDTH+1)'(NUM_CLASS - 1);

    state_t                state;
    logic [IDX_WIDTH:0]    cnt;
    logic [DATA_WIDTH-1:0] max_r;
    logic [IDX_WIDTH-1:0]  idx_r;

    logic                  take_new;
    logic [DATA_WIDTH-1:0] sel_max;
    logic [IDX_WIDTH-1:0]  sel_idx;

    argmax_cmp #(
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_cmp (
        .cur_max  (max_r),
        .cur_idx  (idx_r),
        .new_dat  (in_data),
        .new_idx  (cnt[IDX_WIDTH-1:0]),
        .take_new (take_new),
        .sel_max  (sel_max),
        .sel_idx  (sel_idx)
    );

    // Depends on state only; reset forces IDLE so this reads 1 during reset.
    assign in_ready = (state != HOLD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            max_r     <= '0;
            idx_r     <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_max   <= '0;
        end else if (clear) begin
            // Abort wins over accept and handshake; last result stays on out_idx/out_max.
            state     <= IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        max_r <= in_data;
                        idx_r <= '0;
                        cnt   <= CNT_ONE;
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (in_valid) begin
                        if (take_new) begin
                            max_r <= sel_max;
                            idx_r <= sel_idx;
                        end
                        cnt <= cnt + CNT_ONE;
                        if (cnt == LAST_CNT) begin
                            out_max   <= sel_max;
                            out_idx   <= sel_idx;
                            out_valid <= 1'b1;
                            state     <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        cnt       <= '0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_softmax_argmax.sv
// Bench for softmax_argmax: table-driven frames with a result scoreboard,
// plus hand sequences for backpressure, abort and asynchronous reset.
module tb_softmax_argmax;

    localparam int DW = 16;
    localparam int NC = 10;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_idx;
    logic [DW-1:0] out_max;

    softmax_argmax #(.DATA_WIDTH(DW), .NUM_CLASS(NC), .IDX_WIDTH(IW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_max   (out_max)
    );

    always #5 clk = ~clk;

    typedef struct {
        int s[NC];
        int e_idx;
        int e_max;
    } vec_t;

    typedef struct {
        int idx;
        int mx;
    } res_t;

    vec_t tbl[6];
    res_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    function automatic int sx(input logic [DW-1:0] v);
        return int'($signed(v));
    endfunction

    // Reference argmax, earliest index wins on ties.
    function automatic res_t model(input int s[NC]);
        res_t r;
        r.idx = 0;
        r.mx  = s[0];
        for (int i = 1; i < NC; i++)
            if (s[i] > r.mx) begin
                r.mx  = s[i];
                r.idx = i;
            end
        return r;
    endfunction

    // Result checker: every handshake pops one expected result.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                res_t e;
                e = exp_q.pop_front();
                check("result_idx", int'(out_idx), e.idx);
                check("result_max", sx(out_max), e.mx);
            end
        end
    end

    // Drives beats start..NC-1; returns with the last beat presented, accepted at the next edge.
    task automatic send_frame(input int s[NC], input int start, input bit gaps,
                              input bit push, input int e_idx, input int e_max);
        int i;
        int waited;
        res_t r;
        i = start;
        waited = 0;
        while (i < NC) begin
            @(posedge clk); #1;
            waited++;
            if (waited > 200) begin
                check("send_timeout", i, NC);
                return;
            end
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = DW'(s[i]);
                if (in_ready) i++;
            end
        end
        if (push) begin
            r.idx = e_idx;
            r.mx  = e_max;
            exp_q.push_back(r);
        end
    endtask

    task automatic go_idle();
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int rs[NC];
        res_t m;

        tbl[0].s = '{3, -7, 12, 5, 0, 11, -1, 2, 9, 4};             tbl[0].e_idx = 2; tbl[0].e_max = 12;
        tbl[1].s = '{-5, -5, -5, -5, -2, -5, -5, -2, -5, -5};       tbl[1].e_idx = 4; tbl[1].e_max = -2;
        tbl[2].s = '{-3, -3, -3, -3, -3, -3, -3, -3, -3, -3};       tbl[2].e_idx = 0; tbl[2].e_max = -3;
        tbl[3].s = '{-32768, -32768, -32768, -32768, -32768,
                     -32768, -32768, -32768, -32768, 32767};        tbl[3].e_idx = 9; tbl[3].e_max = 32767;
        tbl[4].s = '{100, 1, 2, 3, 4, 5, 6, 7, 8, 99};              tbl[4].e_idx = 0; tbl[4].e_max = 100;
        tbl[5].s = '{7, 7, 1, 1, 1, 1, 1, 1, 1, 7};                 tbl[5].e_idx = 0; tbl[5].e_max = 7;

        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        #12;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_idx", int'(out_idx), 0);
        check("rst_out_max", sx(out_max), 0);
        @(negedge clk); rst_n = 1'b1;

        // Table pass, gap-free then with random in_valid gaps; timing checked each frame.
        for (int pass = 0; pass < 2; pass++) begin
            for (int t = 0; t < 6; t++) begin
                send_frame(tbl[t].s, 0, pass == 1, 1'b1, tbl[t].e_idx, tbl[t].e_max);
                go_idle();
                @(negedge clk);
                check("lat_out_valid", int'(out_valid), 1);
                check("hold_in_ready", int'(in_ready), 0);
                go_idle();
                @(negedge clk);
                check("vld_one_cycle", int'(out_valid), 0);
                check("idle_in_ready", int'(in_ready), 1);
            end
        end

        // Random frames with gaps against the reference model.
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < NC; i++) rs[i] = int'($urandom_range(0, 65535)) - 32768;
            m = model(rs);
            send_frame(rs, 0, 1'b1, 1'b1, m.idx, m.mx);
            go_idle();
            go_idle();
        end

        // Backpressure: result held for 5 cycles with in_valid high, then next frame starts.
        out_ready = 1'b0;
        send_frame(tbl[0].s, 0, 1'b0, 1'b1, 2, 12);
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_data  = DW'(tbl[1].s[0]);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_out_idx", int'(out_idx), 2);
            check("bp_out_max", sx(out_max), 12);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_next_ready", int'(in_ready), 1);
        send_frame(tbl[1].s, 1, 1'b0, 1'b1, 4, -2);
        go_idle();
        go_idle();

        // Clear while holding a result: no handshake, last result kept.
        out_ready = 1'b0;
        send_frame(tbl[3].s, 0, 1'b0, 1'b0, 0, 0);
        go_idle();
        @(negedge clk);
        check("clr_hold_vld", int'(out_valid), 1);
        @(posedge clk); #1; clear = 1'b1;
        @(posedge clk); #1; clear = 1'b0;
        @(negedge clk);
        check("clr_hold_vld_low", int'(out_valid), 0);
        check("clr_keep_idx", int'(out_idx), 9);
        check("clr_keep_max", sx(out_max), 32767);
        check("clr_in_ready", int'(in_ready), 1);
        out_ready = 1'b1;

        // Clear after 4 beats of a large score; fresh frame must win on its own.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_data  = DW'(30000);
        end
        @(posedge clk); #1; in_valid = 1'b0; clear = 1'b1;
        @(posedge clk); #1; clear = 1'b0;
        @(negedge clk);
        check("abort_vld", int'(out_valid), 0);
        send_frame(tbl[4].s, 0, 1'b0, 1'b1, 0, 100);
        go_idle();
        go_idle();

        // Asynchronous reset while holding a result.
        out_ready = 1'b0;
        send_frame(tbl[0].s, 0, 1'b0, 1'b0, 0, 0);
        go_idle();
        @(negedge clk);
        check("arst_pre_vld", int'(out_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_vld", int'(out_valid), 0);
        check("arst_idx", int'(out_idx), 0);
        check("arst_max", sx(out_max), 0);
        check("arst_in_ready", int'(in_ready), 1);
        @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        check("arst_rel_ready", int'(in_ready), 1);
        send_frame(tbl[5].s, 0, 1'b0, 1'b1, 0, 7);
        go_idle();

        for (int w = 0; w < 50 && exp_q.size() != 0; w++) @(posedge clk);
        check("queue_drain", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
